// File: rtl/code_loader_pkg.sv
// Shared types and defaults for the code-storage loader.
package code_loader_pkg;

    localparam int LINE_W                = 32;
    localparam int DEFAULT_CODE_SIZE     = 12;
    localparam int DEFAULT_MAX_CODE_LINE = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        FLUSH   = 2'd2,
        RESTART = 2'd3
    } state_t;

endpackage

// File: rtl/code_loader.sv
// Streams program words into code storage, then restarts execution at line 0.
// Define CODE_LOADER_CHECKSUM_EN to require a trailing checksum word per load.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int code_size     = DEFAULT_CODE_SIZE,
    parameter int max_code_line = DEFAULT_MAX_CODE_LINE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LINE_W-1:0]    load_length,
    input  logic                 abort,
    input  logic                 in_valid,
    input  logic [code_size-1:0] in_data,
    output logic                 in_ready,
    output logic                 is_write,
    output logic [LINE_W-1:0]    write_line,
    output logic [code_size-1:0] write_data,
    output logic                 core_enable,
    output logic                 core_reset,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

    localparam logic [LINE_W-1:0] MAX_LEN = LINE_W'(max_code_line);

    state_t            state;
    logic [LINE_W-1:0] counter;
    logic [LINE_W-1:0] length;
    logic              program_valid;
`ifdef CODE_LOADER_CHECKSUM_EN
    logic [code_size-1:0] sum;
    logic                 chk_phase;
`endif

    assign in_ready    = (state == LOAD);
    assign busy        = (state != IDLE);
    assign core_enable = (program_valid && state == IDLE) || (state == RESTART);

    // Strobes default low each cycle; a transfer is echoed to storage one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            counter       <= '0;
            length        <= '0;
            program_valid <= 1'b0;
            is_write      <= 1'b0;
            write_line    <= '0;
            write_data    <= '0;
            core_reset    <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
            sum           <= '0;
            chk_phase     <= 1'b0;
`endif
        end else begin
            is_write   <= 1'b0;
            core_reset <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (load_length == '0 || load_length > MAX_LEN) begin
                            error <= 1'b1;
                        end else begin
                            length        <= load_length;
                            counter       <= '0;
                            program_valid <= 1'b0;
                            state         <= LOAD;
`ifdef CODE_LOADER_CHECKSUM_EN
                            sum           <= '0;
                            chk_phase     <= 1'b0;
`endif
                        end
                    end
                end
                LOAD: begin
                    // Abort takes priority over any transfer offered in the same cycle.
                    if (abort) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else if (in_valid) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                        if (chk_phase) begin
                            if (in_data == sum) begin
                                state <= FLUSH;
                            end else begin
                                state         <= IDLE;
                                error         <= 1'b1;
                                program_valid <= 1'b0;
                            end
                        end else begin
                            is_write   <= 1'b1;
                            write_line <= counter;
                            write_data <= in_data;
                            counter    <= counter + 1'b1;
                            sum        <= sum + in_data;
                            if (counter == length - 1'b1)
                                chk_phase <= 1'b1;
                        end
`else
                        is_write   <= 1'b1;
                        write_line <= counter;
                        write_data <= in_data;
                        counter    <= counter + 1'b1;
                        if (counter == length - 1'b1)
                            state <= FLUSH;
`endif
                    end
                end
                FLUSH: begin
                    if (abort) begin
                        state <= IDLE;
                        error <= 1'b1;
                    end else begin
                        state         <= RESTART;
                        core_reset    <= 1'b1;
                        done          <= 1'b1;
                        program_valid <= 1'b1;
                    end
                end
                RESTART: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: handshake-level model plus directed scenarios.
module tb_code_loader;
    import code_loader_pkg::*;

    localparam int CS = 12;
    localparam int ML = 100;
`ifdef CODE_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [31:0]   load_length;
    logic          abort;
    logic          in_valid;
    logic [CS-1:0] in_data;
    logic          in_ready;
    logic          is_write;
    logic [31:0]   write_line;
    logic [CS-1:0] write_data;
    logic          core_enable;
    logic          core_reset;
    logic          busy;
    logic          done;
    logic          error;

    code_loader #(.code_size(CS), .max_code_line(ML)) dut (
        .clk(clk), .reset(reset), .start(start), .load_length(load_length),
        .abort(abort), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .is_write(is_write), .write_line(write_line), .write_data(write_data),
        .core_enable(core_enable), .core_reset(core_reset), .busy(busy),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int line;
        int data;
        int cyc;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    wr_t wlog[$];
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  crst_cnt = 0;
    int  last_done_cyc = 0;

    // Model: a load of N words opens the port for N (+checksum) handshakes; each
    // program-word handshake must appear as a write to the next line one cycle later.
    bit            m_active = 1'b0;
    bit            m_pend = 1'b0;
    int            m_len = 0;
    int            m_cnt = 0;
    int            m_words = 0;
    int            m_line = 0;
    logic [CS-1:0] m_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                m_active = 1'b0;
                m_pend   = 1'b0;
            end else begin
                check("is_write", 32'(is_write), 32'(m_pend));
                if (m_pend) begin
                    check("write_line", write_line, 32'(m_line));
                    check("write_data", 32'(write_data), 32'(m_data));
                end
                check("in_ready", 32'(in_ready), 32'(m_active && m_cnt < m_words));
                check("core_reset_without_enable", 32'(core_reset && !core_enable), 32'd0);
                if (is_write) wlog.push_back('{int'(write_line), int'(write_data), cyc});
                if (done) begin
                    done_cnt++;
                    last_done_cyc = cyc;
                end
                if (error) err_cnt++;
                if (core_reset) crst_cnt++;
                m_pend = 1'b0;
                if (m_active && m_cnt < m_words && in_valid && !abort) begin
                    if (m_cnt < m_len) begin
                        m_pend = 1'b1;
                        m_line = m_cnt;
                        m_data = in_data;
                    end
                    m_cnt++;
                end
                if (abort || m_cnt >= m_words) m_active = 1'b0;
                if (start && load_length >= 1 && load_length <= ML) begin
                    m_active = 1'b1;
                    m_len    = int'(load_length);
                    m_cnt    = 0;
                    m_words  = m_len + CK;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] len);
        start       = 1'b1;
        load_length = len;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [CS-1:0] d, input bit keep);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("send_handshake", 32'(in_ready), 32'd1);
        step();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic check_write(input string name, input int idx, input int line, input int data);
        if (idx < wlog.size()) begin
            check({name, "_line"}, 32'(wlog[idx].line), 32'(line));
            check({name, "_data"}, 32'(wlog[idx].data), 32'(data));
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: write missing, got %0d writes, expected index %0d", name, wlog.size(), idx);
        end
    endtask

    task automatic check_output(input string name, input logic exp_enable, input logic exp_busy);
        check({name, "_core_enable"}, 32'(core_enable), 32'(exp_enable));
        check({name, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        int l0, d0, e0, r0;
        reset       = 1'b1;
        start       = 1'b0;
        load_length = '0;
        abort       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        fork
            monitor();
        join_none
        #1 reset = 1'b0;
        #2;
        check("rst_outputs", {is_write, in_ready, core_enable, core_reset, busy, done, error}, 32'd0);
        check("rst_write_line", write_line, 32'd0);
        step();
        step();
        reset = 1'b1;
        step();

        // Normal load: three back-to-back words.
        l0 = wlog.size(); d0 = done_cnt; r0 = crst_cnt;
        do_start(32'd3);
        send_word(12'h00A, 1'b1);
        send_word(12'h00B, 1'b1);
        send_word(12'h00C, 1'b0);
        repeat (5) step();
        check("normal_nwrites", 32'(wlog.size() - l0), 32'd3);
        check_write("normal_w0", l0, 0, 'h00A);
        check_write("normal_w1", l0 + 1, 1, 'h00B);
        check_write("normal_w2", l0 + 2, 2, 'h00C);
        if (wlog.size() >= l0 + 3) begin
            check("normal_consec1", 32'(wlog[l0+1].cyc - wlog[l0].cyc), 32'd1);
            check("normal_consec2", 32'(wlog[l0+2].cyc - wlog[l0+1].cyc), 32'd1);
            check("normal_done_after_flush", 32'(last_done_cyc - wlog[l0+2].cyc), 32'd1);
        end
        check("normal_done", 32'(done_cnt - d0), 32'd1);
        check("normal_core_reset", 32'(crst_cnt - r0), 32'd1);
        check_output("normal", 1'b1, 1'b0);

        // Rejected lengths leave the loaded program enabled.
        l0 = wlog.size(); e0 = err_cnt;
        do_start(32'd0);
        step();
        check("badlen0_error", 32'(err_cnt - e0), 32'd1);
        check_output("badlen0", 1'b1, 1'b0);
        do_start(32'd101);
        step();
        check("badlen101_error", 32'(err_cnt - e0), 32'd2);
        check("badlen_nwrites", 32'(wlog.size() - l0), 32'd0);
        check_output("badlen101", 1'b1, 1'b0);

        // Gapped stream.
        l0 = wlog.size(); d0 = done_cnt;
        do_start(32'd2);
        repeat (3) step();
        send_word(12'h111, 1'b0);
        repeat (3) step();
        send_word(12'h222, 1'b0);
        repeat (5) step();
        check_write("stall_w0", l0, 0, 'h111);
        check_write("stall_w1", l0 + 1, 1, 'h222);
        check("stall_done", 32'(done_cnt - d0), 32'd1);
        check_output("stall", 1'b1, 1'b0);

        // Abort after one of four words.
        l0 = wlog.size(); d0 = done_cnt; e0 = err_cnt;
        do_start(32'd4);
        send_word(12'h0AA, 1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        check("abort_nwrites", 32'(wlog.size() - l0), 32'd1);
        check_write("abort_w0", l0, 0, 'h0AA);
        check("abort_error", 32'(err_cnt - e0), 32'd1);
        check("abort_done", 32'(done_cnt - d0), 32'd0);
        check_output("abort", 1'b0, 1'b0);
        l0 = wlog.size(); d0 = done_cnt;
        do_start(32'd1);
        send_word(12'h055, 1'b0);
        repeat (5) step();
        check_write("after_abort_w0", l0, 0, 'h055);
        check("after_abort_done", 32'(done_cnt - d0), 32'd1);
        check_output("after_abort", 1'b1, 1'b0);

        // Asynchronous reset between edges, right after a transfer.
        do_start(32'd3);
        send_word(12'h123, 1'b1);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_outputs", {is_write, in_ready, core_enable, core_reset, busy, done, error}, 32'd0);
        check("async_write_line", write_line, 32'd0);
        check("async_write_data", 32'(write_data), 32'd0);
        step();
        reset = 1'b1;
        step();
        check_output("async_release", 1'b0, 1'b0);

`ifdef CODE_LOADER_CHECKSUM_EN
        l0 = wlog.size(); d0 = done_cnt;
        do_start(32'd2);
        send_word(12'h001, 1'b1);
        send_word(12'h002, 1'b1);
        send_word(12'h003, 1'b0);
        repeat (5) step();
        check("cksum_ok_nwrites", 32'(wlog.size() - l0), 32'd2);
        check("cksum_ok_done", 32'(done_cnt - d0), 32'd1);
        check_output("cksum_ok", 1'b1, 1'b0);
        d0 = done_cnt; e0 = err_cnt;
        do_start(32'd2);
        send_word(12'h001, 1'b1);
        send_word(12'h002, 1'b1);
        send_word(12'h004, 1'b0);
        repeat (5) step();
        check("cksum_bad_error", 32'(err_cnt - e0), 32'd1);
        check("cksum_bad_done", 32'(done_cnt - d0), 32'd0);
        check_output("cksum_bad", 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
